ser_seq_ctrl: RTL
=================

SER_SEQ_CTRL -- requirements
Module: ser_seq_ctrl

Interface
REQ-001 Parameter: NBITS, default 8, serial word length in bits.
REQ-002 Parameter: DIV, default 4, clk cycles per serial bit; even, >=2.
REQ-003 Port: clk  input  1  sole clock, all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: req  input  2  per-requester read request; level, held until gnt.
REQ-006 Port: addr0 / addr1  input  4 each  serial word address of requester 0 / 1.
REQ-007 Port: gnt  output  2  one-cycle grant pulse to the selected requester.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: ser_sel_n  output  1  serial device select, active-low.
REQ-010 Port: ser_sclk  output  1  serial shift clock.
REQ-011 Port: ser_addr  output  4  latched address of the granted request.
REQ-012 Port: ser_sdi  input  1  serial read data from the device, MSB first.
REQ-013 Port: rd_data  output  NBITS  assembled read word.
REQ-014 Port: rd_valid  output  1  one-cycle pulse qualifying rd_data, rd_id and par_err.
REQ-015 Port: rd_id  output  1  index of the requester that owns rd_data.
REQ-016 Port: par_err  output  1  parity error flag, qualified by rd_valid.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, SHIFT and DONE, all registered.
REQ-018 In IDLE with any req bit high, the FSM SHALL go to SETUP next cycle; with no req it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; after reset requester 0 wins.
REQ-020 In SETUP the block SHALL pulse gnt[winner], latch ser_addr and rd_id, drive ser_sel_n low, and go to SHIFT.
REQ-021 In SHIFT a divider SHALL count 0..DIV-1 per bit, ser_sclk SHALL be high while divider >= DIV/2, and ser_sdi SHALL be shifted into the LSB of the data register at divider == DIV-1.
REQ-022 After NBITS bit periods the FSM SHALL go to DONE, pulse rd_valid, drive ser_sel_n high and return to IDLE next cycle.
REQ-023 Latency: a req seen in IDLE at cycle t SHALL give gnt at t+1 and rd_valid at t+2+NBITS*DIV.
REQ-024 Back-to-back transfers SHALL keep ser_sel_n high for at least 2 cycles (DONE plus IDLE).
REQ-025 req changes while busy SHALL be ignored; a req dropped before gnt SHALL be treated as withdrawn.
REQ-026 ser_sclk SHALL be low in IDLE, SETUP and DONE.
REQ-027 rd_data SHALL hold its value until the next rd_valid.

Reset
REQ-028 With rst_n low on a clock edge: state IDLE, gnt=0, busy=0, ser_sel_n=1, ser_sclk=0, ser_addr=0, rd_data=0, rd_valid=0, rd_id=0, par_err=0, round-robin pointer favouring requester 0.
REQ-029 Reset during SHIFT SHALL abort the transfer with no rd_valid.

Configuration
REQ-030 With SER_SEQ_PARITY_EN defined, SHIFT SHALL add one extra bit period that samples a parity bit, which is not stored in rd_data.
REQ-031 With SER_SEQ_PARITY_EN defined, par_err SHALL be 1 when the NBITS data bits plus the parity bit hold an even number of ones (odd parity).
REQ-032 With SER_SEQ_PARITY_EN defined, the latency in REQ-023 becomes t+2+(NBITS+1)*DIV.
REQ-033 Without SER_SEQ_PARITY_EN, par_err SHALL be constant 0 and no extra bit period SHALL occur.

Structure
REQ-034 ser_seq_pkg SHALL hold the state enum and the NBITS and DIV default constants.
REQ-035 The 2-way round-robin arbiter SHALL be the sub-module ser_seq_rr_arb.

Verification (NBITS=8, DIV=4, macro off unless stated)
REQ-036 req=01, addr0=5, ser_sdi driven with 0xA5 at t=0 -> gnt=01 at t=1, ser_addr=5, rd_valid at t=34 with rd_data=0xA5, rd_id=0.
REQ-037 req=11 from reset -> requester 0 served first, then requester 1; rd_id sequence 0,1; ser_sel_n high for >=2 cycles between the two transfers.
REQ-038 req1 held constantly while req0 is re-raised after each grant -> grants alternate 0,1,0,1.
REQ-039 rst_n low during bit 3 of SHIFT -> next cycle ser_sel_n=1, ser_sclk=0, busy=0; no rd_valid.
REQ-040 Macro on, data 0x01 with parity bit 1 -> rd_valid at t=38, par_err=1; the same data with parity bit 0 -> par_err=0.
REQ-041 req toggled while busy -> no extra gnt pulse; the current transfer completes unchanged.

Source files
------------

// File: rtl/ser_seq_pkg.sv
// Shared types and default constants for the serial read sequencer.
package ser_seq_pkg;

  localparam int NBITS_DEF = 8;
  localparam int DIV_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ser_seq_rr_arb.sv
// Two-way round-robin arbiter; the tie-break pointer flips away from whoever was last granted.
module ser_seq_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_id,
  output logic       win_id,
  output logic       any_req
);

  logic prio;

  always_comb begin
    any_req = |req;
    win_id  = (req == 2'b11) ? prio : req[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= ~upd_id;
    end
  end

endmodule

// File: rtl/ser_seq_ctrl.sv
// Serial read sequencer: arbitrates two requesters and shifts in one word per grant.
// Optional odd-parity bit period enabled with `define SER_SEQ_PARITY_EN.
module ser_seq_ctrl
  import ser_seq_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int DIV   = DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [3:0]       addr0,
  input  logic [3:0]       addr1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             ser_sel_n,
  output logic             ser_sclk,
  output logic [3:0]       ser_addr,
  input  logic             ser_sdi,
  output logic [NBITS-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_id,
  output logic             par_err,
  output state_t           dbg_state
);

  // Handshake: req is a level held until its one-cycle gnt pulse; dropping it
  // before gnt withdraws it. rd_valid is a one-cycle pulse with no backpressure.

`ifdef SER_SEQ_PARITY_EN
  localparam int NPER = NBITS + 1;
`else
  localparam int NPER = NBITS;
`endif
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(NPER + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(NPER - 1);
`ifdef SER_SEQ_PARITY_EN
  localparam logic [BW-1:0] BIT_PAR  = BW'(NBITS);
  logic par_bit;
`endif

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] shift_sr;
  logic             win_q;
  logic             win_id;
  logic             any_req;
  logic             grant_now;

  assign grant_now = (state == ST_SETUP) && req[win_q];
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  ser_seq_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .update  (grant_now),
    .upd_id  (win_q),
    .win_id  (win_id),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_sr  <= '0;
      win_q     <= 1'b0;
      gnt       <= 2'b00;
      ser_sel_n <= 1'b1;
      ser_sclk  <= 1'b0;
      ser_addr  <= 4'd0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_id     <= 1'b0;
      par_err   <= 1'b0;
`ifdef SER_SEQ_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      gnt      <= 2'b00;
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          ser_sclk <= 1'b0;
          if (any_req) begin
            win_q <= win_id;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // The winner is re-checked here so a request dropped before gnt is withdrawn.
          if (req[win_q]) begin
            gnt       <= id_onehot(win_q);
            ser_addr  <= win_q ? addr1 : addr0;
            rd_id     <= win_q;
            ser_sel_n <= 1'b0;
            ser_sclk  <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            ser_sclk <= 1'b0;
`ifdef SER_SEQ_PARITY_EN
            if (bit_cnt == BIT_PAR) begin
              par_bit <= ser_sdi;
            end else begin
              shift_sr <= {shift_sr[NBITS-2:0], ser_sdi};
            end
`else
            shift_sr <= {shift_sr[NBITS-2:0], ser_sdi};
`endif
            if (bit_cnt == BIT_LAST) begin
              ser_sel_n <= 1'b1;
              state     <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt  <= div_cnt + 1'b1;
            ser_sclk <= (div_cnt + 1'b1) >= DIV_HALF;
          end
        end
        ST_DONE: begin
          ser_sclk <= 1'b0;
          rd_valid <= 1'b1;
          rd_data  <= shift_sr;
`ifdef SER_SEQ_PARITY_EN
          // Odd parity: an even count of ones across data plus parity is an error.
          par_err  <= ~(^shift_sr ^ par_bit);
`else
          par_err  <= 1'b0;
`endif
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
